uart_buffer_datapath: RTL and testbench
=======================================

// Module: uart_buffer_datapath
// PURPOSE
// - Data path of the memory-mapped UART buffer: 1:4 demux for bus write data,
//   2:1 source mux (RX byte vs bus data), and a 2^WORDS x DATA_WIDTH buffer RAM
//   addressed by an internal pointer. Sits between the bus interface/controller
//   FSM and the UART TX/RX engines; the controller drives all selects/strobes.
// PARAMETERS
// - DATA_WIDTH  8  width of every data path
// - WORDS       5  address width; buffer depth = 2**WORDS (32 bytes)
// PORTS
// - clock          in   1           system clock, all state on posedge
// - reset          in   1           asynchronous, active-high reset
// - addr_sel       in   2           demux select (bus address bits [1:0])
// - host_data_i    in   DATA_WIDTH  bus write data
// - dmx0_o         out  DATA_WIDTH  demux ch0 (keycode slot, unused by buffer)
// - dmx1_o         out  DATA_WIDTH  demux ch1 (control1 write data)
// - dmx2_o         out  DATA_WIDTH  demux ch2 (control2 write data)
// - rx_byte_i      in   DATA_WIDTH  byte from UART receiver
// - buff_select_i  in   1           0: RAM writes rx_byte_i; 1: demux ch3
// - wr_n           in   1           active-low RAM write strobe
// - rd_n           in   1           active-low RAM read strobe
// - ptr_clr        in   1           synchronous pointer clear
// - ptr_inc        in   1           synchronous pointer increment
// - ptr_o          out  WORDS       current buffer pointer
// - data_o         out  DATA_WIDTH  registered RAM read data
// BEHAVIOUR
// - Demux (combinational): channel addr_sel = host_data_i, other 3 channels = 0.
//   Ch3 is internal only (feeds source mux).
// - Source mux (combinational): wdata = buff_select_i ? demux ch3 : rx_byte_i.
//   Note: bus data reaches the RAM only when addr_sel==3 and buff_select_i==1;
//   otherwise ch3 is 0 and 0 is written.
// - RAM write: posedge with wr_n==0 -> mem[ptr_o] <= wdata. wr_n==1 -> no change.
// - RAM read: posedge with rd_n==0 -> data_o <= mem[ptr_o]; rd_n==1 -> data_o holds.
//   Latency 1 clock from strobe to data_o.
// - Simultaneous rd_n==0 & wr_n==0: read-before-write; data_o gets old contents,
//   new value stored.
// - Pointer: ptr_clr has priority over ptr_inc; ptr_inc adds 1 modulo 2**WORDS
//   (31 -> 0 wrap, no flag). Strobes in the same cycle use pre-update pointer.
// - Reset (async, immediate): ptr_o = 0, data_o = 0. RAM contents not cleared
//   (undefined until written). While reset high, writes, reads, ptr updates
//   are suppressed. Reset mid-operation aborts the in-flight access; no
//   partial write.
// - Combinational outputs (dmx*_o) follow inputs regardless of reset.
// - No X propagation on data_o after reset even if unwritten address read:
//   implementation may return any value; verification checks only written addrs.
// STRUCTURE
// - Shared package uart_buffer_pkg: DATA_WIDTH/WORDS defaults; select codes
//   SEL_KEYCODE=2'd0, SEL_CTRL1=2'd1, SEL_CTRL2=2'd2, SEL_BUFFER=2'd3;
//   BUFF_SRC_RX=1'b0, BUFF_SRC_HOST=1'b1.
// - One sub-module: buffer_ram (array, write port, registered read, async reset
//   of read register only). Demux, mux and pointer stay inline.
// TESTING
// - Demux: addr_sel 0..3, host_data_i=8'hA5 -> only selected dmx*_o = A5, others
//   0; addr_sel=3 -> dmx0..2 all 0.
// - Host write/read: clr ptr; sel=3, buff_select=1, write 8'h11,22,33 with
//   ptr_inc each; clr; read 3x -> data_o 11,22,33, each 1 clock after rd_n low.
// - RX path: buff_select=0, rx_byte_i=8'h5A, wr_n low at ptr 4 -> read ptr 4 = 5A;
//   buff_select=1 with addr_sel=1 -> writes 00.
// - Wrap/priority: 32 incs from 0 -> ptr_o 0; ptr_clr & ptr_inc same cycle -> 0;
//   write at 31 then inc -> next write lands at 0.
// - Same-cycle rd/wr: mem[2]=8'h77, write 8'h88 with rd_n low -> data_o 77,
//   next read 88.
// - Async reset: assert mid-write burst between edges -> ptr_o, data_o 0 at once;
//   no write on edges while reset high; prior contents intact after release.

Source files
------------

// File: rtl/uart_buffer_pkg.sv
// Shared defaults and select codes for the memory-mapped UART buffer data path.
// Imported by the datapath top and the buffer RAM.
package uart_buffer_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned WORDS_DEF      = 5;

    localparam logic [1:0] SEL_KEYCODE = 2'd0;
    localparam logic [1:0] SEL_CTRL1   = 2'd1;
    localparam logic [1:0] SEL_CTRL2   = 2'd2;
    localparam logic [1:0] SEL_BUFFER  = 2'd3;

    localparam logic BUFF_SRC_RX   = 1'b0;
    localparam logic BUFF_SRC_HOST = 1'b1;

endpackage

// File: rtl/buffer_ram.sv
// Buffer RAM: single write port plus a registered read port.
// Only the read register is reset; the array contents stay undefined until written.
module buffer_ram
    import uart_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned WORDS      = WORDS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [WORDS-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // we_i arrives already qualified with reset, so the array needs no reset term.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Nonblocking read of the same address returns the pre-write contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_buffer_datapath.sv
// UART buffer data path: bus-write demux, RX/host source mux, buffer pointer and
// buffer RAM. All selects and strobes come from the external controller FSM.
module uart_buffer_datapath
    import uart_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned WORDS      = WORDS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            addr_sel,
    input  logic [DATA_WIDTH-1:0] host_data_i,
    output logic [DATA_WIDTH-1:0] dmx0_o,
    output logic [DATA_WIDTH-1:0] dmx1_o,
    output logic [DATA_WIDTH-1:0] dmx2_o,
    input  logic [DATA_WIDTH-1:0] rx_byte_i,
    input  logic                  buff_select_i,
    input  logic                  wr_n,
    input  logic                  rd_n,
    input  logic                  ptr_clr,
    input  logic                  ptr_inc,
    output logic [WORDS-1:0]      ptr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] ch0, ch1, ch2, ch3;
    logic [DATA_WIDTH-1:0] wdata;
    logic [WORDS-1:0]      ptr_q, ptr_d;
    logic                  we, re;

    always_comb begin
        ch0 = '0;
        ch1 = '0;
        ch2 = '0;
        ch3 = '0;
        case (addr_sel)
            SEL_KEYCODE: ch0 = host_data_i;
            SEL_CTRL1:   ch1 = host_data_i;
            SEL_CTRL2:   ch2 = host_data_i;
            SEL_BUFFER:  ch3 = host_data_i;
            default:     ch0 = '0;
        endcase
    end

    assign dmx0_o = ch0;
    assign dmx1_o = ch1;
    assign dmx2_o = ch2;

    // Host data reaches the RAM only via channel 3; any other address writes zero.
    assign wdata = (buff_select_i == BUFF_SRC_RX) ? rx_byte_i : ch3;

    always_comb begin
        ptr_d = ptr_q;
        if (ptr_clr) begin
            ptr_d = '0;
        end else if (ptr_inc) begin
            ptr_d = ptr_q + WORDS'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

    // Writes must not land on edges while reset is held, so gate the strobe here.
    assign we = ~wr_n & ~reset;
    assign re = ~rd_n;

    buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (WORDS)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .we_i    (we),
        .re_i    (re),
        .addr_i  (ptr_q),
        .wdata_i (wdata),
        .rdata_o (data_o)
    );

endmodule

// File: tb/tb_uart_buffer_datapath.sv
// Bench for uart_buffer_datapath: directed scenarios then random traffic,
// compared against an array/pointer model of the buffer's observable behaviour.
module tb_uart_buffer_datapath;

    logic       clock;
    logic       reset;
    logic [1:0] addr_sel;
    logic [7:0] host_data_i;
    logic [7:0] dmx0_o, dmx1_o, dmx2_o;
    logic [7:0] rx_byte_i;
    logic       buff_select_i;
    logic       wr_n, rd_n, ptr_clr, ptr_inc;
    logic [4:0] ptr_o;
    logic [7:0] data_o;

    uart_buffer_datapath #(
        .DATA_WIDTH (8),
        .WORDS      (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .addr_sel      (addr_sel),
        .host_data_i   (host_data_i),
        .dmx0_o        (dmx0_o),
        .dmx1_o        (dmx1_o),
        .dmx2_o        (dmx2_o),
        .rx_byte_i     (rx_byte_i),
        .buff_select_i (buff_select_i),
        .wr_n          (wr_n),
        .rd_n          (rd_n),
        .ptr_clr       (ptr_clr),
        .ptr_inc       (ptr_inc),
        .ptr_o         (ptr_o),
        .data_o        (data_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: byte array, known-written flags, pointer, last read byte.
    logic [7:0]  m_mem [32];
    bit          m_wr  [32];
    int unsigned m_ptr;
    logic [7:0]  m_data;
    bit          m_known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] src_byte();
        if (buff_select_i == 1'b0) return rx_byte_i;
        return (addr_sel == 2'd3) ? host_data_i : 8'h00;
    endfunction

    task automatic model_edge();
        logic [7:0] old;
        bit         oldv;
        if (reset) return;
        old  = m_mem[m_ptr];
        oldv = m_wr[m_ptr];
        if (!rd_n) begin
            m_data  = old;
            m_known = oldv;
        end
        if (!wr_n) begin
            m_mem[m_ptr] = src_byte();
            m_wr[m_ptr]  = 1'b1;
        end
        if (ptr_clr) m_ptr = 0;
        else if (ptr_inc) m_ptr = (m_ptr + 1) % 32;
    endtask

    task automatic check_dmx(input string tag);
        check({tag, "_dmx0"}, dmx0_o, (addr_sel == 2'd0) ? host_data_i : 8'h00);
        check({tag, "_dmx1"}, dmx1_o, (addr_sel == 2'd1) ? host_data_i : 8'h00);
        check({tag, "_dmx2"}, dmx2_o, (addr_sel == 2'd2) ? host_data_i : 8'h00);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cyc(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check({tag, "_ptr"}, ptr_o, m_ptr);
        if (m_known) check({tag, "_data"}, data_o, m_data);
    endtask

    task automatic idle();
        wr_n = 1'b1; rd_n = 1'b1; ptr_clr = 1'b0; ptr_inc = 1'b0;
    endtask

    task automatic clr_ptr();
        idle(); ptr_clr = 1'b1; cyc("clr"); ptr_clr = 1'b0;
    endtask

    task automatic goto_ptr(input int unsigned p);
        clr_ptr();
        ptr_inc = 1'b1;
        for (int unsigned i = 0; i < p; i++) cyc("seek");
        ptr_inc = 1'b0;
    endtask

    logic [7:0] hw_vals [3];

    initial begin
        hw_vals[0] = 8'h11; hw_vals[1] = 8'h22; hw_vals[2] = 8'h33;
        for (int unsigned i = 0; i < 32; i++) m_wr[i] = 1'b0;
        m_ptr = 0; m_data = 8'h00; m_known = 1'b1;

        reset = 1'b1; addr_sel = 2'd0; host_data_i = 8'h00; rx_byte_i = 8'h00;
        buff_select_i = 1'b0; idle();
        repeat (2) @(posedge clock);
        #1;
        check("rst_ptr", ptr_o, 5'd0);
        check("rst_data", data_o, 8'h00);
        reset = 1'b0;

        // Demux
        host_data_i = 8'hA5;
        for (int unsigned s = 0; s < 4; s++) begin
            addr_sel = 2'(s);
            #1;
            check("dmx_sel0", dmx0_o, (s == 0) ? 8'hA5 : 8'h00);
            check("dmx_sel1", dmx1_o, (s == 1) ? 8'hA5 : 8'h00);
            check("dmx_sel2", dmx2_o, (s == 2) ? 8'hA5 : 8'h00);
        end

        // Host write then read back
        clr_ptr();
        addr_sel = 2'd3; buff_select_i = 1'b1; wr_n = 1'b0; ptr_inc = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            host_data_i = hw_vals[i];
            cyc("hw_wr");
        end
        clr_ptr();
        rd_n = 1'b0; ptr_inc = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            cyc("hw_rd");
            check("hw_rd_const", data_o, hw_vals[i]);
        end
        idle();

        // RX path, then host select with non-buffer address writes zero
        goto_ptr(4);
        buff_select_i = 1'b0; rx_byte_i = 8'h5A; wr_n = 1'b0; cyc("rx_wr");
        wr_n = 1'b1; rd_n = 1'b0; cyc("rx_rd");
        check("rx_rd_const", data_o, 8'h5A);
        rd_n = 1'b1;
        buff_select_i = 1'b1; addr_sel = 2'd1; host_data_i = 8'hA5;
        wr_n = 1'b0; cyc("zero_wr");
        wr_n = 1'b1; rd_n = 1'b0; cyc("zero_rd");
        check("zero_rd_const", data_o, 8'h00);
        idle();

        // Pointer wrap and clear priority
        clr_ptr();
        ptr_inc = 1'b1;
        for (int unsigned i = 0; i < 32; i++) cyc("wrap");
        check("wrap_const", ptr_o, 5'd0);
        cyc("inc1");
        ptr_clr = 1'b1; cyc("clr_prio");
        check("clr_prio_const", ptr_o, 5'd0);
        idle();
        goto_ptr(31);
        addr_sel = 2'd3; buff_select_i = 1'b1; wr_n = 1'b0; ptr_inc = 1'b1;
        host_data_i = 8'hC3; cyc("wr31");
        host_data_i = 8'h3C; cyc("wr0");
        idle();
        clr_ptr();
        rd_n = 1'b0; cyc("rd0");
        check("rd0_const", data_o, 8'h3C);
        idle();
        goto_ptr(31);
        rd_n = 1'b0; cyc("rd31");
        check("rd31_const", data_o, 8'hC3);
        idle();

        // Same-cycle read and write
        goto_ptr(2);
        host_data_i = 8'h77; wr_n = 1'b0; cyc("rw_pre");
        host_data_i = 8'h88; rd_n = 1'b0; cyc("rw_both");
        check("rw_old_const", data_o, 8'h77);
        wr_n = 1'b1; cyc("rw_new");
        check("rw_new_const", data_o, 8'h88);
        idle();

        // Async reset in the middle of a write burst
        clr_ptr();
        wr_n = 1'b0; ptr_inc = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            host_data_i = 8'(8'hD0 + i);
            cyc("burst");
        end
        host_data_i = 8'hEE;
        #3 reset = 1'b1;
        #1;
        m_ptr = 0; m_data = 8'h00; m_known = 1'b1;
        check("arst_ptr", ptr_o, 5'd0);
        check("arst_data", data_o, 8'h00);
        rd_n = 1'b0;
        cyc("in_rst");
        cyc("in_rst");
        idle();
        #3 reset = 1'b0;
        ptr_inc = 1'b1; rd_n = 1'b0;
        for (int unsigned i = 0; i < 5; i++) cyc("post_rst");
        check("post_rst_m4", data_o, 8'h00);
        idle();

        // Random traffic against the model
        for (int unsigned n = 0; n < 600; n++) begin
            addr_sel      = 2'($urandom_range(0, 3));
            host_data_i   = 8'($urandom);
            rx_byte_i     = 8'($urandom);
            buff_select_i = 1'($urandom);
            wr_n          = ($urandom_range(0, 2) == 0);
            rd_n          = ($urandom_range(0, 2) == 0);
            ptr_inc       = ($urandom_range(0, 1) == 0);
            ptr_clr       = ($urandom_range(0, 15) == 0);
            #1;
            check_dmx("rnd");
            cyc("rnd");
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
